// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared defaults, types and helpers for the output arbiter
package noc_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef logic [DATA_W_DEF-1:0] flit_t;
    typedef logic [ID_W_DEF-1:0]   src_id_t;

    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin search starting at the pointer
module rr_grant
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    winner_o
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                winner_o      = idx;
            end
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// rtl/rr_output_arbiter.sv - round-robin arbiter feeding one registered output stage
module rr_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_si,
    input  logic [NUM_REQ*DATA_W-1:0] req_di,
    output logic [NUM_REQ-1:0]        req_ri,
    input  logic                      out_ro,
    output logic                      out_so,
    output logic [DATA_W-1:0]         out_do,
    output logic [ID_W-1:0]           out_src
);

    logic              out_so_q, out_so_d;
    logic [DATA_W-1:0] out_do_q, out_do_d;
    logic [ID_W-1:0]   out_src_q, out_src_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               can_load;
    logic               load;
    logic [DATA_W-1:0]  sel_flit;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_i    (req_si),
        .ptr_i    (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // Register may load when empty or when its current flit leaves this same edge.
    assign can_load = arb_en & (~out_so_q | out_ro);
    assign req_ri   = can_load ? grant : '0;
    assign load     = |(req_si & req_ri);

    // One-hot AND-OR select keeps non-granted lanes (possibly X) out of the register.
    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_flit = sel_flit | req_di[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_so_d  = out_so_q;
        out_do_d  = out_do_q;
        out_src_d = out_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (load) begin
            out_so_d  = 1'b1;
            out_do_d  = sel_flit;
            out_src_d = winner;
            rr_ptr_d  = ID_W'(mod_inc(int'(winner), NUM_REQ));
        end else if (out_so_q && out_ro) begin
            out_so_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_so_q  <= 1'b0;
            out_do_q  <= '0;
            out_src_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            out_so_q  <= out_so_d;
            out_do_q  <= out_do_d;
            out_src_q <= out_src_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign out_so  = out_so_q;
    assign out_do  = out_do_q;
    assign out_src = out_src_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb/tb_rr_output_arbiter.sv - directed self-checking bench for rr_output_arbiter
module tb_rr_output_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              arb_en;
    logic [NREQ-1:0]   req_si;
    logic [NREQ*DW-1:0] req_di;
    logic [NREQ-1:0]   req_ri;
    logic              out_ro;
    logic              out_so;
    logic [DW-1:0]     out_do;
    logic [1:0]        out_src;

    int n_chk  = 0;
    int n_pass = 0;
    int n_acc  = 0;
    int n_del  = 0;

    rr_output_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .arb_en  (arb_en),
        .req_si  (req_si),
        .req_di  (req_di),
        .req_ri  (req_ri),
        .out_ro  (out_ro),
        .out_so  (out_so),
        .out_do  (out_do),
        .out_src (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [63:0] v);
        req_di[i*DW +: DW] = v;
    endtask

    initial begin
        reset  = 1'b0;
        arb_en = 1'b1;
        req_si = '0;
        out_ro = 1'b1;
        req_di = '0;
        for (int i = 0; i < NREQ; i++) set_lane(i, 64'hA0 + 64'(i));
        step();
        step();
        reset = 1'b1;
        #1;

        // 1: idle
        for (int c = 0; c < 5; c++) begin
            chk("idle_ri", 64'(req_ri), 64'h0);
            step();
            chk("idle_so", 64'(out_so), 64'h0);
            chk("idle_do", out_do, 64'h0);
        end

        // 2: all requesting, full throughput rotation
        req_si = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rot_ri", 64'(req_ri), 64'(4'b0001 << (c % 4)));
            step();
            chk("rot_so", 64'(out_so), 64'h1);
            chk("rot_src", 64'(out_src), 64'(c % 4));
            chk("rot_do", out_do, 64'hA0 + 64'(c % 4));
        end

        // 3: load 0xDEAD from req 2 then stall
        req_si = 4'b0100;
        set_lane(2, 64'hDEAD);
        #1;
        chk("ld2_ri", 64'(req_ri), 64'h4);
        step();
        chk("ld2_do", out_do, 64'hDEAD);
        set_lane(2, 64'hA2);
        out_ro = 1'b0;
        req_si = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ri", 64'(req_ri), 64'h0);
            step();
            chk("stall_so", 64'(out_so), 64'h1);
            chk("stall_do", out_do, 64'hDEAD);
            chk("stall_src", 64'(out_src), 64'h2);
        end
        out_ro = 1'b1;
        #1;
        chk("unstall_ri", 64'(req_ri), 64'h8);
        step();
        chk("unstall_src", 64'(out_src), 64'h3);
        chk("unstall_do", out_do, 64'hA3);

        // 4: single requester with toggling downstream ready
        req_si = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            out_ro = (c % 2 == 0);
            #1;
            chk("tog_ri", 64'(req_ri), (c % 2 == 0) ? 64'h2 : 64'h0);
            if (|(req_si & req_ri)) n_acc++;
            if (out_so && out_ro) n_del++;
            step();
            chk("tog_src", 64'(out_src), 64'h1);
        end
        req_si = '0;
        out_ro = 1'b1;
        #1;
        if (out_so && out_ro) n_del++;
        step();
        chk("tog_drain_so", 64'(out_so), 64'h0);
        chk("tog_acc", 64'(n_acc), 64'd2);
        chk("tog_del", 64'(n_del), 64'd3);

        // 5: arb_en low drains but does not grant; pointer preserved
        req_si = 4'b0001;
        step();
        chk("en_ld_src", 64'(out_src), 64'h0);
        arb_en = 1'b0;
        req_si = 4'b1111;
        #1;
        chk("dis_ri", 64'(req_ri), 64'h0);
        step();
        chk("dis_so", 64'(out_so), 64'h0);
        chk("dis_ri2", 64'(req_ri), 64'h0);
        step();
        chk("dis_so2", 64'(out_so), 64'h0);
        arb_en = 1'b1;
        #1;
        chk("reen_ri", 64'(req_ri), 64'h2);
        step();
        chk("reen_src", 64'(out_src), 64'h1);
        chk("reen_do", out_do, 64'hA1);

        // 6: asynchronous reset during a stall
        out_ro = 1'b0;
        step();
        chk("pre_rst_so", 64'(out_so), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_so", 64'(out_so), 64'h0);
        chk("arst_do", out_do, 64'h0);
        chk("arst_src", 64'(out_src), 64'h0);
        step();
        reset  = 1'b1;
        out_ro = 1'b1;
        #1;
        chk("post_rst_ri", 64'(req_ri), 64'h1);
        step();
        chk("post_rst_src", 64'(out_src), 64'h0);
        chk("post_rst_do", out_do, 64'hA0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
